// File: rtl/rr_lock_arb_pkg.sv
// Shared types and helpers for the round-robin burst-locking arbiter.
package rr_lock_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    // Binary index of a one-hot vector (up to 32 requesters); zero when empty.
    function automatic logic [31:0] onehot2bin(input logic [31:0] oh);
        logic [31:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx |= 32'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_lock_arb_if.sv
// Requester-side and downstream-side signals of the arbiter.
interface rr_lock_arb_if
    import rr_lock_arb_pkg::*;
#(
    parameter int  WIDTH    = 3,
    parameter int  ID_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    parameter type PLD_TYPE = logic
);

    logic [WIDTH-1:0] v_vld_s;
    logic [WIDTH-1:0] v_rdy_s;
    PLD_TYPE          v_pld_s [WIDTH];
    logic [WIDTH-1:0] v_last_s;

    logic             vld_m;
    logic             rdy_m;
    PLD_TYPE          pld_m;
    logic             last_m;
    logic [ID_W-1:0]  id_m;

    modport master (
        input  v_vld_s, v_pld_s, v_last_s, rdy_m,
        output v_rdy_s, vld_m, pld_m, last_m, id_m
    );

    modport slave (
        output v_vld_s, v_pld_s, v_last_s, rdy_m,
        input  v_rdy_s, vld_m, pld_m, last_m, id_m
    );

endinterface

// File: rtl/rr_lock_arb_rr_pick.sv
// Combinational masked round-robin picker: the first request strictly after
// ptr wins, otherwise the lowest-indexed request (wrap-around).
module rr_pick
    import rr_lock_arb_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int ID_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [WIDTH-1:0] gnt_o
);

    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] req_hi;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
        assign mask[gi] = (ID_W'(gi) > ptr_i);
    end

    assign req_hi = req_i & mask;

    // x & -x isolates the lowest set bit.
    assign gnt_o = (|req_hi) ? (req_hi & (~req_hi + WIDTH'(1)))
                             : (req_i  & (~req_i  + WIDTH'(1)));

endmodule

// File: rtl/rr_lock_arb.sv
// Round-robin arbiter with burst locking and a registered output beat.
// rdy_m reaches v_rdy_s only through the pipe-ready term.
module rr_lock_arb
    import rr_lock_arb_pkg::*;
#(
    parameter type PLD_TYPE = logic,
    parameter int  WIDTH    = 3,
    parameter int  ID_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_lock_arb_if.master bus
);

    arb_state_e       state_q;
    logic [ID_W-1:0]  owner_q;
    logic [ID_W-1:0]  ptr_q;

    logic             vld_q;
    PLD_TYPE          pld_q;
    logic             last_q;
    logic [ID_W-1:0]  id_q;

    logic [WIDTH-1:0] pick_gnt;
    logic [WIDTH-1:0] owner_oh;
    logic [WIDTH-1:0] gnt;
    logic [WIDTH-1:0] rdy;
    logic [ID_W-1:0]  gnt_id;
    logic             pipe_rdy;
    logic             acc;
    PLD_TYPE          acc_pld;
    logic             acc_last;

    rr_pick #(
        .WIDTH (WIDTH),
        .ID_W  (ID_W)
    ) u_pick (
        .req_i (bus.v_vld_s),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt)
    );

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_owner
        assign owner_oh[gi] = (owner_q == ID_W'(gi));
    end

    // Nothing is accepted while reset is held, so no beat slips into a
    // register that is being cleared.
    assign pipe_rdy = rst_n & (~vld_q | bus.rdy_m);
    assign gnt      = (state_q == ST_LOCK) ? (owner_oh & bus.v_vld_s) : pick_gnt;
    assign rdy      = gnt & {WIDTH{pipe_rdy}};
    assign acc      = |(rdy & bus.v_vld_s);
    assign gnt_id   = ID_W'(onehot2bin(32'(gnt)));

    always_comb begin
        acc_pld  = bus.v_pld_s[gnt_id];
        acc_last = bus.v_last_s[gnt_id];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= ID_W'(WIDTH - 1);
            vld_q   <= 1'b0;
            pld_q   <= '0;
            last_q  <= 1'b0;
            id_q    <= '0;
        end else begin
            if (pipe_rdy) begin
                vld_q <= acc;
                if (acc) begin
                    pld_q  <= acc_pld;
                    last_q <= acc_last;
                    id_q   <= gnt_id;
                end
            end

            // ptr only moves when a whole transfer (single beat or burst) ends.
            if (acc) begin
                case (state_q)
                    ST_IDLE: begin
                        if (acc_last) begin
                            ptr_q <= gnt_id;
                        end else begin
                            owner_q <= gnt_id;
                            state_q <= ST_LOCK;
                        end
                    end
                    ST_LOCK: begin
                        if (acc_last) begin
                            ptr_q   <= owner_q;
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.v_rdy_s = rdy;
    assign bus.vld_m   = vld_q;
    assign bus.pld_m   = pld_q;
    assign bus.last_m  = last_q;
    assign bus.id_m    = id_q;

    a_rdy_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus.v_rdy_s));

endmodule
